// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the core-side memory responder:
// store size encodings, port FSM states and byte-lane helpers.
package cpu_mem_pkg;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic {
        IDLE,
        BUSY
    } port_state_t;

    function automatic logic store_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return ((size == SIZE_HALF) && off[0])
            || ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

    // Misaligned half/word stores yield an empty mask so nothing is written.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SIZE_BYTE: m = 4'b0001 << off;
            SIZE_HALF: m = off[0] ? 4'b0000 : (4'b0011 << off);
            SIZE_WORD: m = (off == 2'b00) ? 4'b1111 : 4'b0000;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One request port: latches the request, counts down its latency,
// then asks the arbiter for the array slot until granted.
module mem_port_fsm
    import cpu_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        grant_i,
    output logic        wait_o,
    output logic        slot_req_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  size_o
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    port_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic          wait_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SIZE_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_q <= BUSY;
                        wait_q  <= 1'b1;
                        cnt_q   <= CW'(LATENCY - 1);
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        size_q  <= size_i;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (grant_i) begin
                        state_q <= IDLE;
                        wait_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign slot_req_o = (state_q == BUSY) && (cnt_q == '0);
    assign wait_o     = wait_q;
    assign addr_o     = addr_q;
    assign wdata_o    = wdata_q;
    assign size_o     = size_q;

endmodule

// File: rtl/memory_responder.sv
// Fetch + load/store responder over one single-slot word RAM.
// Array contents start undefined; load them via stores.
module memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int INST_LATENCY = 1,
    parameter int DATA_LATENCY = 2,
    parameter     INIT_FILE    = "program.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_ready,
    input  logic [31:0] instruction_address,
    output logic [31:0] instruction,
    output logic        instruction_wait,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_data_store,
    input  logic        memory_read,
    input  logic [1:0]  memory_write,
    output logic [31:0] memory_data_load,
    output logic        memory_wait,
    output logic        misaligned_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        i_slot, i_grant;
    logic [31:0] i_addr;
    logic [31:0] unused_i_wdata;
    logic [1:0]  unused_i_size;

    logic        d_req, d_slot, d_grant, d_is_store;
    logic [31:0] d_addr, d_wdata, d_wdata_sh, d_word;
    logic [1:0]  d_size, d_off;
    logic [3:0]  d_mask;
    logic [63:0] d_rot;

    logic [31:0] instr_q, load_q;
    logic        mis_q;

    assign d_req = memory_read || (memory_write != SIZE_NONE);

    mem_port_fsm #(.LATENCY(INST_LATENCY)) u_inst_port (
        .clk_i      (clk),
        .rst_ni     (rst),
        .req_i      (instruction_ready),
        .addr_i     (instruction_address),
        .wdata_i    (32'h0),
        .size_i     (SIZE_NONE),
        .grant_i    (i_grant),
        .wait_o     (instruction_wait),
        .slot_req_o (i_slot),
        .addr_o     (i_addr),
        .wdata_o    (unused_i_wdata),
        .size_o     (unused_i_size)
    );

    mem_port_fsm #(.LATENCY(DATA_LATENCY)) u_data_port (
        .clk_i      (clk),
        .rst_ni     (rst),
        .req_i      (d_req),
        .addr_i     (memory_address),
        .wdata_i    (memory_data_store),
        .size_i     (memory_write),
        .grant_i    (d_grant),
        .wait_o     (memory_wait),
        .slot_req_o (d_slot),
        .addr_o     (d_addr),
        .wdata_o    (d_wdata),
        .size_o     (d_size)
    );

    assign d_grant = d_slot;
    assign i_grant = i_slot && !d_slot;

    assign d_off      = d_addr[1:0];
    assign d_is_store = (d_size != SIZE_NONE);
    assign d_mask     = lane_mask(d_size, d_off);
    assign d_wdata_sh = d_wdata << {d_off, 3'b000};
    assign d_word     = mem_q[d_addr[AW+1:2]];
    assign d_rot      = {d_word, d_word} >> {d_off, 3'b000};

    always_ff @(posedge clk) begin
        if (d_grant && d_is_store) begin
            for (int b = 0; b < 4; b++) begin
                if (d_mask[b]) begin
                    mem_q[d_addr[AW+1:2]][8*b +: 8] <= d_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            load_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            mis_q <= d_grant && d_is_store
                  && store_misaligned(d_size, d_off);
            if (i_grant) begin
                instr_q <= mem_q[i_addr[AW+1:2]];
            end
            if (d_grant && !d_is_store) begin
                load_q <= d_rot[31:0];
            end
        end
    end

    assign instruction      = instr_q;
    assign memory_data_load = load_q;
    assign misaligned_error = mis_q;

    logic unused_bits;
    assign unused_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2],
                           unused_i_wdata, unused_i_size, d_rot[63:32]};

    localparam int unused_init_bits = $bits(INIT_FILE);

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder against a byte-level
// memory model with fixed fetch/data latencies.
module tb_memory_responder;
    import cpu_mem_pkg::*;

    localparam int ILAT = 1;
    localparam int DLAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instruction_ready = 1'b0;
    logic [31:0] instruction_address = '0;
    logic [31:0] instruction;
    logic        instruction_wait;
    logic [31:0] memory_address = '0;
    logic [31:0] memory_data_store = '0;
    logic        memory_read = 1'b0;
    logic [1:0]  memory_write = 2'b00;
    logic [31:0] memory_data_load;
    logic        memory_wait;
    logic        misaligned_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [1024];

    memory_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction_ready   (instruction_ready),
        .instruction_address (instruction_address),
        .instruction         (instruction),
        .instruction_wait    (instruction_wait),
        .memory_address      (memory_address),
        .memory_data_store   (memory_data_store),
        .memory_read         (memory_read),
        .memory_write        (memory_write),
        .memory_data_load    (memory_data_load),
        .memory_wait         (memory_wait),
        .misaligned_error    (misaligned_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_load(input logic [31:0] a);
        logic [31:0] r;
        int base;
        base = int'(a[9:0]) & ~3;
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = mb[base + ((int'(a[1:0]) + k) % 4)];
        return r;
    endfunction

    function automatic logic m_bad(input logic [31:0] a, input logic [1:0] sz);
        if (sz == SIZE_HALF) return (a % 2) != 0;
        if (sz == SIZE_WORD) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz);
        int n;
        int base;
        n = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        base = int'(a[9:0]);
        if (!m_bad(a, sz))
            for (int k = 0; k < n; k++) mb[base + k] = d[8*k +: 8];
    endtask

    task automatic data_op(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic rd,
                           output logic [31:0] ld, output int lat,
                           output logic mis);
        @(negedge clk);
        memory_address = a;
        memory_data_store = d;
        memory_write = sz;
        memory_read = rd;
        @(negedge clk);
        memory_read = 1'b0;
        memory_write = SIZE_NONE;
        memory_address = $urandom;
        memory_data_store = $urandom;
        lat = 0;
        while (memory_wait && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        ld = memory_data_load;
        mis = misaligned_error;
    endtask

    task automatic fetch_op(input logic [31:0] a, output logic [31:0] ins,
                            output int lat);
        @(negedge clk);
        instruction_address = a;
        instruction_ready = 1'b1;
        @(negedge clk);
        instruction_ready = 1'b0;
        instruction_address = $urandom;
        lat = 0;
        while (instruction_wait && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        ins = instruction;
    endtask

    task automatic test_reset;
        logic [31:0] ld;
        int lat;
        logic mis;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (instruction_wait !== 1'b0) begin
            errors++; $display("FAIL reset_iwait: got %b expected 0", instruction_wait);
        end
        if (memory_wait !== 1'b0) begin
            errors++; $display("FAIL reset_mwait: got %b expected 0", memory_wait);
        end
        if (instruction !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h expected 0", instruction);
        end
        if (memory_data_load !== 32'h0) begin
            errors++; $display("FAIL reset_load: got %h expected 0", memory_data_load);
        end
        if (misaligned_error !== 1'b0) begin
            errors++; $display("FAIL reset_mis: got %b expected 0", misaligned_error);
        end
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            data_op(i * 4, w, SIZE_WORD, 1'b0, ld, lat, mis);
            m_store(i * 4, w, SIZE_WORD);
        end
    endtask

    task automatic test_fetch_basic;
        logic [31:0] ld, ins;
        int lat;
        logic mis;
        data_op(32'h0, 32'h00500093, SIZE_WORD, 1'b0, ld, lat, mis);
        m_store(32'h0, 32'h00500093, SIZE_WORD);
        fetch_op(32'h0, ins, lat);
        checks += 2;
        if (lat != ILAT) begin
            errors++; $display("FAIL fetch_lat: got %0d expected %0d", lat, ILAT);
        end
        if (ins !== 32'h00500093) begin
            errors++; $display("FAIL fetch_data: got %h expected 00500093", ins);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] ld;
        int lat;
        logic mis;
        data_op(32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, ld, lat, mis);
        m_store(32'h10, 32'hDEADBEEF, SIZE_WORD);
        checks += 2;
        if (lat != DLAT) begin
            errors++; $display("FAIL store_lat: got %0d expected %0d", lat, DLAT);
        end
        if (mis !== 1'b0) begin
            errors++; $display("FAIL store_mis: got %b expected 0", mis);
        end
        data_op(32'h12, 32'h0, SIZE_NONE, 1'b1, ld, lat, mis);
        checks += 3;
        if (lat != DLAT) begin
            errors++; $display("FAIL load_lat: got %0d expected %0d", lat, DLAT);
        end
        if (ld[7:0] !== 8'hAD) begin
            errors++; $display("FAIL load_byte: got %h expected ad", ld[7:0]);
        end
        if (ld !== m_load(32'h12)) begin
            errors++; $display("FAIL load_rot: got %h expected %h", ld, m_load(32'h12));
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] ld;
        int lat;
        logic mis;
        data_op(32'h13, 32'h1234, SIZE_HALF, 1'b0, ld, lat, mis);
        checks += 2;
        if (mis !== 1'b1) begin
            errors++; $display("FAIL mis_pulse: got %b expected 1", mis);
        end
        if (lat != DLAT) begin
            errors++; $display("FAIL mis_lat: got %0d expected %0d", lat, DLAT);
        end
        @(negedge clk);
        checks++;
        if (misaligned_error !== 1'b0) begin
            errors++; $display("FAIL mis_width: got %b expected 0", misaligned_error);
        end
        data_op(32'h10, 32'h0, SIZE_NONE, 1'b1, ld, lat, mis);
        checks++;
        if (ld !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mis_nowrite: got %h expected deadbeef", ld);
        end
    endtask

    task automatic test_contention;
        @(negedge clk);
        memory_address = 32'h14;
        memory_read = 1'b1;
        @(negedge clk);
        memory_read = 1'b0;
        instruction_address = 32'h8;
        instruction_ready = 1'b1;
        @(negedge clk);
        instruction_ready = 1'b0;
        checks += 2;
        if (memory_wait !== 1'b1) begin
            errors++; $display("FAIL arb_mwait1: got %b expected 1", memory_wait);
        end
        if (instruction_wait !== 1'b1) begin
            errors++; $display("FAIL arb_iwait1: got %b expected 1", instruction_wait);
        end
        @(negedge clk);
        checks += 3;
        if (memory_wait !== 1'b0) begin
            errors++; $display("FAIL arb_mdone: got %b expected 0", memory_wait);
        end
        if (memory_data_load !== m_load(32'h14)) begin
            errors++; $display("FAIL arb_load: got %h expected %h",
                               memory_data_load, m_load(32'h14));
        end
        if (instruction_wait !== 1'b1) begin
            errors++; $display("FAIL arb_iheld: got %b expected 1", instruction_wait);
        end
        @(negedge clk);
        checks += 2;
        if (instruction_wait !== 1'b0) begin
            errors++; $display("FAIL arb_idone: got %b expected 0", instruction_wait);
        end
        if (instruction !== m_load(32'h8)) begin
            errors++; $display("FAIL arb_fetch: got %h expected %h",
                               instruction, m_load(32'h8));
        end
    endtask

    task automatic test_raw;
        @(negedge clk);
        memory_address = 32'h20;
        memory_data_store = 32'hABCDEF77;
        memory_write = SIZE_BYTE;
        @(negedge clk);
        memory_write = SIZE_NONE;
        @(negedge clk);
        instruction_address = 32'h20;
        instruction_ready = 1'b1;
        @(negedge clk);
        instruction_ready = 1'b0;
        m_store(32'h20, 32'hABCDEF77, SIZE_BYTE);
        checks++;
        if (memory_wait !== 1'b0) begin
            errors++; $display("FAIL raw_store: got %b expected 0", memory_wait);
        end
        @(negedge clk);
        checks += 2;
        if (instruction[7:0] !== 8'h77) begin
            errors++; $display("FAIL raw_byte: got %h expected 77", instruction[7:0]);
        end
        if (instruction !== m_load(32'h20)) begin
            errors++; $display("FAIL raw_word: got %h expected %h",
                               instruction, m_load(32'h20));
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] ld;
        int lat;
        logic mis;
        @(negedge clk);
        memory_address = 32'h40;
        memory_data_store = ~m_load(32'h40);
        memory_write = SIZE_WORD;
        @(negedge clk);
        memory_write = SIZE_NONE;
        checks++;
        if (memory_wait !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy: got %b expected 1", memory_wait);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (memory_wait !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got %b expected 0", memory_wait);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        data_op(32'h40, 32'h0, SIZE_NONE, 1'b1, ld, lat, mis);
        checks += 2;
        if (lat != DLAT) begin
            errors++; $display("FAIL rstmid_lat: got %0d expected %0d", lat, DLAT);
        end
        if (ld !== m_load(32'h40)) begin
            errors++; $display("FAIL rstmid_data: got %h expected %h", ld, m_load(32'h40));
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        instruction_address = 32'h4;
        instruction_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (instruction_wait !== ((k % 2) == 0)) begin
                errors++; $display("FAIL b2b_wait%0d: got %b expected %b",
                                   k, instruction_wait, (k % 2) == 0);
            end
            if ((k % 2) == 1) begin
                checks++;
                if (instruction !== m_load(32'h4)) begin
                    errors++; $display("FAIL b2b_data%0d: got %h expected %h",
                                       k, instruction, m_load(32'h4));
                end
            end
        end
        instruction_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] a, d, ld, ins, exp;
        logic [1:0] sz;
        logic rd, mis;
        int lat;
        for (int i = 0; i < 60; i++) begin
            a = 32'($urandom_range(0, 251));
            if ($urandom_range(0, 3) == 0) begin
                exp = m_load(a & ~32'h3);
                fetch_op(a, ins, lat);
                checks += 2;
                if (lat != ILAT) begin
                    errors++; $display("FAIL rnd_flat%0d: got %0d expected %0d", i, lat, ILAT);
                end
                if (ins !== exp) begin
                    errors++; $display("FAIL rnd_fetch%0d: got %h expected %h", i, ins, exp);
                end
            end else begin
                d = $urandom;
                sz = 2'($urandom_range(0, 3));
                rd = 1'($urandom);
                if (sz == SIZE_NONE) rd = 1'b1;
                exp = m_load(a);
                data_op(a, d, sz, rd, ld, lat, mis);
                checks += 2;
                if (lat != DLAT) begin
                    errors++; $display("FAIL rnd_dlat%0d: got %0d expected %0d", i, lat, DLAT);
                end
                if (mis !== ((sz != SIZE_NONE) && m_bad(a, sz))) begin
                    errors++; $display("FAIL rnd_mis%0d: got %b expected %b",
                                       i, mis, (sz != SIZE_NONE) && m_bad(a, sz));
                end
                if (sz == SIZE_NONE) begin
                    checks++;
                    if (ld !== exp) begin
                        errors++; $display("FAIL rnd_load%0d: got %h expected %h", i, ld, exp);
                    end
                end else begin
                    m_store(a, d, sz);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_store_load();
        test_misaligned();
        test_contention();
        test_raw();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
